// File: rtl/pc_next_select.sv
// Fetch-stage program counter: picks the next PC among increment, branch, jump and
// exception sources, and parks one redirect that arrives while fetch is stalled.
module pc_next_select #(
   parameter int unsigned PC_W     = 12,
   parameter int unsigned INC      = 4,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned EXC_VEC  = 32'h0000_0080
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_ready,
   input  logic            br_cond,
   input  logic [PC_W-1:0] br_target,
   input  logic            jmp_en,
   input  logic [PC_W-1:0] jmp_target,
   input  logic            exc_req,
   output logic [PC_W-1:0] pc,
   output logic            pc_valid,
   output logic [1:0]      pc_src,
   output logic            redirect_pending
);

   localparam logic [PC_W-1:0] INC_PC   = PC_W'(INC);
   localparam logic [PC_W-1:0] RST_PC   = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] EXC_PC   = PC_W'(EXC_VEC);

   localparam logic [1:0] SRC_SEQ = 2'd0;
   localparam logic [1:0] SRC_BR  = 2'd1;
   localparam logic [1:0] SRC_JMP = 2'd2;
   localparam logic [1:0] SRC_EXC = 2'd3;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [PC_W-1:0] pc_r, pc_s;
   logic [1:0]      src_r, src_s;
   logic            valid_r, valid_s;
   logic            pend_r, pend_s;
   logic [PC_W-1:0] pend_tgt_r, pend_tgt_s;
   logic [1:0]      pend_src_r, pend_src_s;

   logic            redir_s;
   logic [PC_W-1:0] redir_tgt_s;
   logic [1:0]      redir_src_s;

   // Redirect arbitration: exception beats jump beats branch.
   always_comb begin
      redir_s     = 1'b0;
      redir_tgt_s = '0;
      redir_src_s = SRC_SEQ;
      if (exc_req) begin
         redir_s     = 1'b1;
         redir_tgt_s = EXC_PC;
         redir_src_s = SRC_EXC;
      end else if (jmp_en) begin
         redir_s     = 1'b1;
         redir_tgt_s = jmp_target;
         redir_src_s = SRC_JMP;
      end else if (br_cond) begin
         redir_s     = 1'b1;
         redir_tgt_s = br_target;
         redir_src_s = SRC_BR;
      end else begin
         redir_s     = 1'b0;
      end
   end

   // Next-state and next-PC selection.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      src_s      = src_r;
      valid_s    = valid_r;
      pend_s     = pend_r;
      pend_tgt_s = pend_tgt_r;
      pend_src_s = pend_src_r;
      case (state_r)
         ST_INIT: begin
            // Redirects are ignored until the PC is declared valid.
            state_s = ST_RUN;
            valid_s = 1'b1;
         end
         ST_RUN: begin
            if (fetch_ready) begin
               if (redir_s) begin
                  pc_s  = redir_tgt_s;
                  src_s = redir_src_s;
               end else if (pend_r) begin
                  pc_s  = pend_tgt_r;
                  src_s = pend_src_r;
               end else begin
                  pc_s  = pc_r + INC_PC;
                  src_s = SRC_SEQ;
               end
               pend_s = 1'b0;
            end else if (redir_s) begin
               // Newest stalled redirect replaces any older one, whatever its class.
               pend_s     = 1'b1;
               pend_tgt_s = redir_tgt_s;
               pend_src_s = redir_src_s;
            end else begin
               pend_s = pend_r;
            end
         end
         default: begin
            state_s = ST_INIT;
            valid_s = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_INIT;
         pc_r       <= RST_PC;
         src_r      <= SRC_EXC;
         valid_r    <= 1'b0;
         pend_r     <= 1'b0;
         pend_tgt_r <= '0;
         pend_src_r <= SRC_SEQ;
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         src_r      <= src_s;
         valid_r    <= valid_s;
         pend_r     <= pend_s;
         pend_tgt_r <= pend_tgt_s;
         pend_src_r <= pend_src_s;
      end
   end

   assign pc               = pc_r;
   assign pc_src           = src_r;
   assign pc_valid         = valid_r;
   assign redirect_pending = pend_r;

endmodule

// File: tb/tb_pc_next_select.sv
// Self-checking bench for pc_next_select: a reference model pushes expected
// {pc, pc_src, pc_valid, redirect_pending} per cycle; the DUT result is popped and compared.
module tb_pc_next_select;

   logic        clk;
   logic        rst_n;
   logic        fetch_ready;
   logic        br_cond;
   logic [11:0] br_target;
   logic        jmp_en;
   logic [11:0] jmp_target;
   logic        exc_req;
   logic [11:0] pc;
   logic        pc_valid;
   logic [1:0]  pc_src;
   logic        redirect_pending;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] sb_q[$];
   logic [15:0] exp_v;
   wire  [15:0] obs_v = {pc, pc_src, pc_valid, redirect_pending};

   // Reference model state
   logic        m_run, m_valid, m_pend;
   logic [11:0] m_pc, m_ptgt;
   logic [1:0]  m_src, m_psrc;

   pc_next_select dut (
      .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
      .br_cond(br_cond), .br_target(br_target),
      .jmp_en(jmp_en), .jmp_target(jmp_target), .exc_req(exc_req),
      .pc(pc), .pc_valid(pc_valid), .pc_src(pc_src),
      .redirect_pending(redirect_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_init();
      m_run = 1'b0; m_valid = 1'b0; m_pend = 1'b0;
      m_pc = 12'h000; m_src = 2'd3; m_ptgt = 12'h000; m_psrc = 2'd0;
      sb_q.delete();
   endtask

   // Apply one cycle of inputs, predict the outcome, push it, and advance past the edge.
   task automatic drive(input logic fr, input logic br, input logic [11:0] bt,
                        input logic jp, input logic [11:0] jt, input logic ex);
      logic        has;
      logic [11:0] tgt;
      logic [1:0]  src;
      fetch_ready = fr; br_cond = br; br_target = bt;
      jmp_en = jp; jmp_target = jt; exc_req = ex;
      has = ex | jp | br;
      tgt = ex ? 12'h080 : (jp ? jt : bt);
      src = ex ? 2'd3 : (jp ? 2'd2 : 2'd1);
      if (!m_run) begin
         m_run = 1'b1; m_valid = 1'b1;
      end else if (fr) begin
         if (has)         begin m_pc = tgt;    m_src = src;    end
         else if (m_pend) begin m_pc = m_ptgt; m_src = m_psrc; end
         else             begin m_pc = m_pc + 12'd4; m_src = 2'd0; end
         m_pend = 1'b0;
      end else if (has) begin
         m_pend = 1'b1; m_ptgt = tgt; m_psrc = src;
      end
      sb_q.push_back({m_pc, m_src, m_valid, m_pend});
      @(posedge clk);
      #1;
      br_cond = 1'b0; jmp_en = 1'b0; exc_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_init();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      fetch_ready = 1'b1; br_cond = 1'b0; jmp_en = 1'b0; exc_req = 1'b0;
      br_target = 12'h000; jmp_target = 12'h000;
      rst_n = 1'b0;
      model_init();
      #12;
      n_vec++;
      if (obs_v !== 16'h000C) begin
         n_err++; $display("FAIL reset_state: got %h want %h", obs_v, 16'h000C);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
         exp_v = sb_q.pop_front();
         n_vec++;
         if (obs_v !== exp_v) begin
            n_err++; $display("FAIL seq_%0d: got %h want %h", i, obs_v, exp_v);
         end
      end
      n_vec++;
      if (pc !== 12'd12 || pc_src !== 2'd0 || pc_valid !== 1'b1) begin
         n_err++; $display("FAIL seq_end: got pc=%h src=%0d v=%b want pc=00c src=0 v=1", pc, pc_src, pc_valid);
      end
   endtask

   task automatic test_init_ignores();
      do_reset();
      drive(1'b1, 1'b1, 12'h040, 1'b1, 12'h100, 1'b1);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || pc !== 12'h000) begin
         n_err++; $display("FAIL init_ignore: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_priority();
      do_reset();
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      repeat (3) void'(sb_q.pop_front());
      n_vec++;
      if (pc !== 12'h008) begin
         n_err++; $display("FAIL prio_start: got pc=%h want 008", pc);
      end
      drive(1'b1, 1'b1, 12'h040, 1'b1, 12'h100, 1'b1);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || pc !== 12'h080 || pc_src !== 2'd3) begin
         n_err++; $display("FAIL prio_exc: got %h want %h", obs_v, exp_v);
      end
      drive(1'b1, 1'b1, 12'h040, 1'b1, 12'h100, 1'b0);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || pc !== 12'h100 || pc_src !== 2'd2) begin
         n_err++; $display("FAIL prio_jmp: got %h want %h", obs_v, exp_v);
      end
      drive(1'b1, 1'b1, 12'h040, 1'b0, 12'h100, 1'b0);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || pc !== 12'h040 || pc_src !== 2'd1) begin
         n_err++; $display("FAIL prio_br: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_stall();
      drive(1'b0, 1'b1, 12'h200, 1'b0, 12'h000, 1'b0);
      drive(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         exp_v = sb_q.pop_front();
         if (i == 3) begin
            n_vec++;
            if (obs_v !== exp_v || obs_v !== {12'h204, 2'd0, 1'b1, 1'b0}) begin
               n_err++; $display("FAIL stall_after: got %h want %h", obs_v, exp_v);
            end
         end
      end
      // Re-run cycle by cycle so each step is checked at its own edge.
      drive(1'b0, 1'b1, 12'h200, 1'b0, 12'h000, 1'b0);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || pc !== 12'h204 || redirect_pending !== 1'b1) begin
         n_err++; $display("FAIL stall_hold: got %h want %h", obs_v, exp_v);
      end
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || obs_v !== {12'h200, 2'd1, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL stall_release: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_overwrite();
      drive(1'b0, 1'b1, 12'h200, 1'b0, 12'h000, 1'b0);
      drive(1'b0, 1'b0, 12'h000, 1'b1, 12'h300, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      repeat (2) void'(sb_q.pop_front());
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || obs_v !== {12'h300, 2'd2, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL overwrite: got %h want %h", obs_v, exp_v);
      end
      // Exception parked, then a later branch in the same stall still wins.
      drive(1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b1);
      drive(1'b0, 1'b1, 12'h500, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      repeat (2) void'(sb_q.pop_front());
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || obs_v !== {12'h500, 2'd1, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL newest_wins: got %h want %h", obs_v, exp_v);
      end
      drive(1'b0, 1'b1, 12'h200, 1'b0, 12'h000, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b1, 12'h300, 1'b0);
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      void'(sb_q.pop_front());
      exp_v = sb_q.pop_front();
      n_vec++;
      if (sb_q.size() != 1 || obs_v === exp_v) begin
         // obs_v now reflects the cycle after the override; compare it to the last entry.
      end
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || obs_v !== {12'h304, 2'd0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL override: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b0, 12'h000, 1'b1, 12'hFFC, 1'b0);
      void'(sb_q.pop_front());
      drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
      exp_v = sb_q.pop_front();
      n_vec++;
      if (obs_v !== exp_v || obs_v !== {12'h000, 2'd0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL wrap: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b1, 12'h200, 1'b0, 12'h000, 1'b0);
      void'(sb_q.pop_front());
      n_vec++;
      if (redirect_pending !== 1'b1) begin
         n_err++; $display("FAIL async_pre: got pend=%b want 1", redirect_pending);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs_v !== 16'h000C) begin
         n_err++; $display("FAIL async_reset: got %h want %h", obs_v, 16'h000C);
      end
      model_init();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0);
         exp_v = sb_q.pop_front();
         n_vec++;
         if (obs_v !== exp_v) begin
            n_err++; $display("FAIL async_after_%0d: got %h want %h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
               12'($urandom), 1'($urandom_range(0, 4) == 0),
               12'($urandom), 1'($urandom_range(0, 9) == 0));
         exp_v = sb_q.pop_front();
         n_vec++;
         if (obs_v !== exp_v) begin
            n_err++; $display("FAIL random_%0d: got %h want %h", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init_ignores();
      test_priority();
      test_stall();
      test_overwrite();
      test_wrap();
      test_async_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
